// File: rtl/result_pkg.sv
// -----------------------------------------------------------------------------
// result_pkg
//   Shared defaults and helper functions for the result packing stage.
//   Contents:
//     W_DEFAULT      default packed word width
//     DEPTH_DEFAULT  default FIFO depth (power of two)
//     clog2()        ceiling log2 for sizing pointers and counters
//     even_parity()  XOR reduction used for the optional per-entry parity bit
// -----------------------------------------------------------------------------
package result_pkg;

    localparam int W_DEFAULT     = 8;
    localparam int DEPTH_DEFAULT = 4;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Even parity over up to 64 data bits; zero-extension leaves the XOR unchanged.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
//   Synchronous single-clock FIFO. Pointers carry one extra wrap bit so that
//   full and empty are told apart by comparing the pointers alone.
//   A push while full is accepted only if a pop happens on the same edge.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (clears pointers and storage)
//   push       write request, push_data is the word to store
//   pop        read request, ignored while empty
//   pop_data   head word, zero while empty
//   full       DEPTH entries held
//   empty      no entries held
//   count      occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module result_fifo
    import result_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [clog2(DEPTH):0]    count
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0] mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic         full_s;
    logic         empty_s;
    logic         pop_ok_s;
    logic         push_ok_s;

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_ok_s  = pop && !empty_s;
    // When full, the slot being written is the one being read out this edge.
    assign push_ok_s = push && (!full_s || pop_ok_s);

    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = wr_ptr_r - rd_ptr_r;
    assign pop_data = empty_s ? '0 : mem_r[rd_ptr_r[AW-1:0]];

    // Pointer and storage update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/result_packer.sv
// -----------------------------------------------------------------------------
// result_packer
//   Collects result bits strobed by the instruction control unit, packs them
//   MSB-first into W-bit words and queues completed words in a DEPTH-entry
//   FIFO drained over a valid/ready handshake. A flush pushes a partial word
//   right-aligned. A word that finds the FIFO full (with no pop that edge) is
//   dropped and the sticky overflow flag is set.
// Configuration:
//   RESULT_PARITY_EN  when defined, each entry stores an even-parity bit and
//                     the out_parity port presents it for the head word.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset, priority over all inputs
//   write      result strobe
//   result     result bit, sampled when write=1
//   flush      push the partial word now
//   out_ready  consumer ready
//   out_valid  FIFO head valid
//   out_data   FIFO head word
//   out_parity even parity of out_data (RESULT_PARITY_EN only)
//   out_count  FIFO occupancy 0..DEPTH
//   overflow   sticky: a word was dropped
// -----------------------------------------------------------------------------
module result_packer
    import result_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic                  result,
    input  logic                  flush,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [W-1:0]          out_data,
    output logic [clog2(DEPTH):0] out_count,
`ifdef RESULT_PARITY_EN
    output logic                  out_parity,
`endif
    output logic                  overflow
);

    localparam int             BCW       = clog2(W);
    localparam logic [BCW-1:0] BCNT_LAST = BCW'(W - 1);
`ifdef RESULT_PARITY_EN
    localparam int             FW        = W + 1;
`else
    localparam int             FW        = W;
`endif

    logic [W-1:0]   sreg_r;
    logic [BCW-1:0] bcnt_r;
    logic           overflow_r;

    logic [W-1:0]   sreg_nxt_s;
    logic [BCW-1:0] bcnt_nxt_s;
    logic           push_s;
    logic [W-1:0]   push_word_s;
    logic [FW-1:0]  fifo_in_s;
    logic [FW-1:0]  fifo_out_s;
    logic           full_s;
    logic           empty_s;
    logic           pop_s;
    logic           drop_s;

    // Next shift-register state and push request from write and flush.
    always_comb begin
        sreg_nxt_s  = sreg_r;
        bcnt_nxt_s  = bcnt_r;
        push_s      = 1'b0;
        push_word_s = '0;
        if (write) begin
            if (bcnt_r == BCNT_LAST) begin
                push_s      = 1'b1;
                push_word_s = {sreg_r[W-2:0], result};
                sreg_nxt_s  = '0;
                bcnt_nxt_s  = '0;
            end else begin
                sreg_nxt_s  = {sreg_r[W-2:0], result};
                bcnt_nxt_s  = bcnt_r + BCW'(1);
            end
        end else begin
            sreg_nxt_s = sreg_r;
            bcnt_nxt_s = bcnt_r;
        end
        // Bits above bcnt are always zero, so the partial word is already
        // right-aligned. A completing write has pushed already: no second push.
        if (flush && !push_s && (bcnt_nxt_s != '0)) begin
            push_s      = 1'b1;
            push_word_s = sreg_nxt_s;
            sreg_nxt_s  = '0;
            bcnt_nxt_s  = '0;
        end else begin
            push_word_s = push_word_s;
        end
    end

`ifdef RESULT_PARITY_EN
    assign fifo_in_s  = {even_parity(64'(push_word_s)), push_word_s};
    assign out_parity = fifo_out_s[W];
`else
    assign fifo_in_s  = push_word_s;
`endif

    assign pop_s  = !empty_s && out_ready;
    assign drop_s = push_s && full_s && !pop_s;

    // Packing state and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_r     <= '0;
            bcnt_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            sreg_r     <= sreg_nxt_s;
            bcnt_r     <= bcnt_nxt_s;
            overflow_r <= overflow_r | drop_s;
        end
    end

    result_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (fifo_in_s),
        .pop       (pop_s),
        .pop_data  (fifo_out_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (out_count)
    );

    assign out_valid = !empty_s;
    assign out_data  = fifo_out_s[W-1:0];
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_result_packer.sv
module tb_result_packer;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write = 1'b0;
    logic       result = 1'b0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_count;
    logic       overflow;
`ifdef RESULT_PARITY_EN
    logic       out_parity;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: pending bits, modelled FIFO contents, expected pops.
    bit model_bits[$];
    int mq[$];
    int exp_q[$];
    bit model_ovf = 1'b0;

    result_packer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .write     (write),
        .result    (result),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count),
`ifdef RESULT_PARITY_EN
        .out_parity(out_parity),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic int pack_bits();
        int v = 0;
        foreach (model_bits[i]) v = v * 2 + int'(model_bits[i]);
        return v;
    endfunction

    function automatic bit parity_of(input int word);
        logic [7:0] b;
        b = word[7:0];
        return ^b;
    endfunction

    task automatic check_state();
        int h;
        chk("count", 32'(out_count), 32'(mq.size()));
        chk("valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("overflow", 32'(overflow), 32'(model_ovf));
        if (mq.size() > 0) begin
            h = mq[0];
            chk("head_data", 32'(out_data), 32'(h));
`ifdef RESULT_PARITY_EN
            chk("head_parity", 32'(out_parity), 32'(parity_of(h)));
`endif
        end
    endtask

    // One clock: update model from the spec rules, drive, then check.
    task automatic step(input bit w, input bit r, input bit f, input bit rdy);
        bit do_pop;
        bit do_push;
        int word;
        do_pop  = (mq.size() > 0) && rdy;
        do_push = 1'b0;
        word    = 0;
        if (w) begin
            model_bits.push_back(r);
            if (model_bits.size() == W) begin
                do_push = 1'b1;
                word    = pack_bits();
                model_bits.delete();
            end
        end
        if (f && !do_push && model_bits.size() > 0) begin
            do_push = 1'b1;
            word    = pack_bits();
            model_bits.delete();
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(word);
                exp_q.push_back(word);
            end else begin
                model_ovf = 1'b1;
            end
        end
        write = w; result = r; flush = f; out_ready = rdy;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        write = 1'b0; result = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_bits.delete();
        mq.delete();
        exp_q.delete();
        model_ovf = 1'b0;
        check_state();
        chk("reset_data", 32'(out_data), 32'd0);
    endtask

    task automatic rand_word(input bit rdy);
        bit b;
        for (int i = 0; i < W; i++) begin
            b = 1'($urandom_range(0, 1));
            step(1'b1, b, 1'b0, rdy);
        end
    endtask

    task automatic drain();
        repeat (DEPTH + 2) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every handshake must deliver the oldest expected word.
    always @(negedge clk) begin
        int e;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0h expected no word", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("pop_data", 32'(out_data), 32'(e));
`ifdef RESULT_PARITY_EN
                chk("pop_parity", 32'(out_parity), 32'(parity_of(e)));
`endif
            end
        end
    end

    initial begin
        bit b1 [8];
        bit w, r, f, rdy;
        b1 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Test 1: single packed word, MSB first.
        for (int i = 0; i < 8; i++) step(1'b1, b1[i], 1'b0, 1'b0);
        chk("t1_data", 32'(out_data), 32'h0000_00B2);
        chk("t1_count", 32'(out_count), 32'd1);

        // Test 2: four more words with no consumer; the fifth is dropped.
        for (int k = 0; k < 4; k++) rand_word(1'b0);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_count", 32'(out_count), 32'd4);
        drain();

        // Test 3: full FIFO, completing write coincides with a pop.
        do_reset();
        for (int k = 0; k < 4; k++) rand_word(1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3_overflow", 32'(overflow), 32'd0);
        chk("t3_count", 32'(out_count), 32'd4);
        drain();

        // Test 4: partial flush, then a flush with nothing pending.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_data", 32'(out_data), 32'h0000_0005);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_noflush", 32'(out_count), 32'd1);
        // Flush together with the completing write: single push.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_single_push", 32'(out_count), 32'd2);
        drain();

        // Test 5: reset mid-word with words queued.
        rand_word(1'b0);
        rand_word(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        chk("t5_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_data", 32'(out_data), 32'h0000_00FF);
        drain();

        // Test 6: parity samples B2 and 07.
        for (int i = 0; i < 8; i++) step(1'b1, b1[i], 1'b0, 1'b0);
`ifdef RESULT_PARITY_EN
        chk("t6_parity_b2", 32'(out_parity), 32'd0);
`endif
        drain();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_data_07", 32'(out_data), 32'h0000_0007);
`ifdef RESULT_PARITY_EN
        chk("t6_parity_07", 32'(out_parity), 32'd1);
`endif
        drain();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                w   = ($urandom_range(0, 3) != 0);
                r   = 1'($urandom_range(0, 1));
                f   = ($urandom_range(0, 9) == 0);
                rdy = ($urandom_range(0, 2) == 0);
                step(w, r, f, rdy);
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
